// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, field moduli and BCD helpers for the clock counters.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } repeat_state_t;

  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    logic [6:0] r;
    r = v % 7'd10;
    return r[3:0];
  endfunction

endpackage

// File: rtl/adjust_repeat.sv
// rtl/adjust_repeat.sv - press-and-hold auto-repeat for up/down adjust buttons.
// Steps are combinational strobes so the consumer commits them on the next edge.
module adjust_repeat
  import clock_pkg::*;
#(
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic clk,
  input  logic clear_n,
  input  logic enable,
  input  logic hold,
  input  logic up,
  input  logic dn,
  output logic step_up,
  output logic step_dn
);

  localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  repeat_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_up_q, dir_up_d;
  logic          single, same_dir, step;

  assign single   = up ^ dn;
  assign same_dir = single && (up == dir_up_q);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      dir_up_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      dir_up_q <= dir_up_d;
    end
  end

  // hold freezes the whole machine, so releasing it resumes mid-count.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dir_up_d = dir_up_q;
    step     = 1'b0;
    if (!hold) begin
      if (!enable) begin
        state_d = IDLE;
        timer_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (single) begin
              step     = 1'b1;
              dir_up_d = up;
              timer_d  = DELAY_LOAD;
              state_d  = DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (!same_dir) begin
              state_d = IDLE;
              timer_d = '0;
            end else if (timer_q == '0) begin
              step    = 1'b1;
              timer_d = PERIOD_LOAD;
              state_d = REPEAT;
            end else begin
              timer_d = timer_q - TW'(1);
            end
          end
          default: begin
            state_d = IDLE;
            timer_d = '0;
          end
        endcase
      end
    end
    step_up = step & dir_up_d;
    step_dn = step & ~dir_up_d;
  end

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N time-digit counter with preset, adjust repeat and BCD split.
module mod_counter
  import clock_pkg::*;
#(
  parameter int  MODULUS       = 24,
  parameter int  REPEAT_DELAY  = 16,
  parameter int  REPEAT_PERIOD = 4,
  localparam int WIDTH         = $clog2(MODULUS)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             tick,
  input  logic             keep,
  input  logic             adjust,
  input  logic             adj_up,
  input  logic             adj_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             carry,
  output logic             at_zero
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             step_up, step_dn;
  logic             at_max, load_ok;

  // Assert asynchronously, release two edges later to avoid recovery hazards.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  adjust_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_adjust_repeat (
    .clk    (clk),
    .clear_n(rst_n),
    .enable (adjust),
    .hold   (keep),
    .up     (adj_up),
    .dn     (adj_dn),
    .step_up(step_up),
    .step_dn(step_dn)
  );

  assign at_max  = (value_q == MAX_V);
  assign load_ok = ({1'b0, load_value} < MOD_EXT);

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        value_d = load_value;
      end
    end else if (!keep && adjust) begin
      if (step_up) begin
        value_d = at_max ? '0 : value_q + WIDTH'(1);
      end else if (step_dn) begin
        value_d = (value_q == '0) ? MAX_V : value_q - WIDTH'(1);
      end
    end else if (!keep && tick) begin
      value_d = at_max ? '0 : value_q + WIDTH'(1);
      carry_d = at_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value   = value_q;
  assign carry   = carry_q;
  assign at_zero = (value_q == '0);
  assign tens    = bcd_tens(7'(value_q));
  assign ones    = bcd_ones(7'(value_q));

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - randomized and directed bench for mod_counter against an age-based model.
module tb_mod_counter;

  localparam int D = 16;
  localparam int P = 4;

  logic       clk = 1'b0;
  logic       clear_n, tick, keep, adjust, adj_up, adj_dn, load;
  logic [4:0] lv24, v24;
  logic [5:0] lv60, v60;
  logic [3:0] tens24, ones24, tens60, ones60;
  logic       carry24, carry60, zero24, zero60;

  int n_checks = 0;
  int n_fail   = 0;

  int mods[2] = '{24, 60};
  int mv[2];
  int mc[2];
  bit pr, pdir;
  int age, rcnt;
  int v0, ncarry;

  always #5 clk = ~clk;

  mod_counter #(.MODULUS(24), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut24 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .keep(keep), .adjust(adjust),
    .adj_up(adj_up), .adj_dn(adj_dn), .load(load), .load_value(lv24),
    .value(v24), .tens(tens24), .ones(ones24), .carry(carry24), .at_zero(zero24)
  );

  mod_counter #(.MODULUS(60), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut60 (
    .clk(clk), .clear_n(clear_n), .tick(tick), .keep(keep), .adjust(adjust),
    .adj_up(adj_up), .adj_dn(adj_dn), .load(load), .load_value(lv60),
    .value(v60), .tens(tens60), .ones(ones60), .carry(carry60), .at_zero(zero60)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0;
      mc[i] = 0;
    end
    pr  = 1'b0;
    age = 0;
  endtask

  // Press age counts unfrozen held cycles; steps fall at age 0, D, D+P, D+2P, ...
  task automatic model_update();
    bit st, one;
    int lvi;
    st = 1'b0;
    if (!clear_n) begin
      model_reset();
      rcnt = 2;
      return;
    end
    if (rcnt > 0) begin
      rcnt--;
      model_reset();
      return;
    end
    one = adj_up ^ adj_dn;
    if (keep) begin
    end else if (!adjust) begin
      pr = 1'b0;
    end else if (pr) begin
      if (one && (adj_up == pdir)) begin
        age++;
        if (age == D || (age > D && (age - D) % P == 0)) st = 1'b1;
      end else begin
        pr = 1'b0;
      end
    end else if (one) begin
      pr   = 1'b1;
      pdir = adj_up;
      age  = 0;
      st   = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0;
      lvi   = (i == 0) ? int'(lv24) : int'(lv60);
      if (load) begin
        if (lvi < mods[i]) mv[i] = lvi;
      end else if (keep) begin
      end else if (adjust) begin
        if (st) mv[i] = pdir ? (mv[i] + 1) % mods[i] : (mv[i] + mods[i] - 1) % mods[i];
      end else if (tick) begin
        mc[i] = (mv[i] == mods[i] - 1) ? 1 : 0;
        mv[i] = (mv[i] + 1) % mods[i];
      end
    end
  endtask

  task automatic compare_all();
    check_eq("value24", v24, mv[0]);
    check_eq("carry24", carry24, mc[0]);
    check_eq("at_zero24", zero24, mv[0] == 0);
    check_eq("tens24", tens24, mv[0] / 10);
    check_eq("ones24", ones24, mv[0] % 10);
    check_eq("value60", v60, mv[1]);
    check_eq("carry60", carry60, mc[1]);
    check_eq("at_zero60", zero60, mv[1] == 0);
    check_eq("tens60", tens60, mv[1] / 10);
    check_eq("ones60", ones60, mv[1] % 10);
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    tick = 0; keep = 0; adjust = 0; adj_up = 0; adj_dn = 0; load = 0;
    lv24 = '0; lv60 = '0;
  endtask

  initial begin
    idle_inputs();
    clear_n = 1'b0;
    rcnt = 2;
    model_reset();
    #1;
    check_eq("reset_value", v24, 0);
    check_eq("reset_at_zero", zero24, 1);
    check_eq("reset_carry", carry24, 0);
    check_eq("reset_bcd", {tens24, ones24}, 0);
    repeat (2) step_cycle();
    clear_n = 1'b1;
    repeat (3) step_cycle();

    // 24 ticks: one wrap, one carry
    tick = 1; ncarry = 0;
    for (int c = 0; c < 24; c++) begin
      step_cycle();
      ncarry += int'(carry24);
      if (c == 22) check_eq("bcd_at_23", {tens24, ones24}, 8'h23);
    end
    check_eq("carry_count24", ncarry, 1);
    check_eq("wrap_value24", v24, 0);

    // Preset and out-of-range preset
    tick = 0; load = 1; lv60 = 6'd59; lv24 = 5'd20;
    step_cycle();
    load = 0; tick = 1;
    step_cycle();
    check_eq("load59_tick_value", v60, 0);
    check_eq("load59_tick_carry", carry60, 1);
    tick = 0; load = 1; lv60 = 6'd62; lv24 = 5'd30;
    step_cycle();
    check_eq("load_oor_ignored60", v60, 0);
    check_eq("load_oor_ignored24", v24, 21);
    load = 0;

    // Single down step from 0, then 30-cycle hold of up
    load = 1; lv24 = 0; lv60 = 0; step_cycle(); load = 0;
    adjust = 1; adj_dn = 1; step_cycle(); adj_dn = 0;
    check_eq("dn_wrap24", v24, 23);
    check_eq("dn_no_carry", carry24, 0);
    step_cycle();
    v0 = int'(v24);
    adj_up = 1;
    repeat (30) step_cycle();
    check_eq("hold30_steps", v24, (v0 + 5) % 24);

    // Keep freezes ticks and the repeat timer
    adj_up = 0; step_cycle();
    adj_up = 1; repeat (8) step_cycle();
    keep = 1; tick = 1; v0 = int'(v24);
    repeat (10) step_cycle();
    check_eq("keep_frozen", v24, v0);
    keep = 0; tick = 0;
    repeat (12) step_cycle();

    // Both buttons, then direction switch mid-repeat
    repeat (20) step_cycle();
    adj_dn = 1; v0 = int'(v24);
    repeat (6) step_cycle();
    check_eq("both_no_step", v24, v0);
    adj_up = 0;
    repeat (D + 3) step_cycle();

    // Async reset mid-repeat
    adj_dn = 0; adj_up = 1;
    repeat (22) step_cycle();
    load = 1; lv24 = 5'd17; lv60 = 6'd17; step_cycle(); load = 0;
    check_eq("pre_reset17", v24, 17);
    #2 clear_n = 1'b0;
    #1;
    check_eq("async_reset_value", v24, 0);
    check_eq("async_reset_at_zero", zero24, 1);
    model_reset();
    step_cycle();
    clear_n = 1'b1;
    repeat (24) step_cycle();

    // Randomized traffic
    idle_inputs();
    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 40) == 0);
      lv24 = 5'($urandom);
      lv60 = 6'($urandom);
      if ($urandom_range(0, 30) == 0) keep = ~keep;
      if ($urandom_range(0, 60) == 0) adjust = ~adjust;
      if ($urandom_range(0, 25) == 0) adj_up = ~adj_up;
      if ($urandom_range(0, 45) == 0) adj_dn = ~adj_dn;
      step_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
